// File: rtl/aoc_axil_seq_pkg.sv
// Shared types and constants for the aoc AXI4-Lite command sequencer.
package aoc_axil_seq_pkg;

  localparam int SEQ_ADDR_W = 4;
  localparam int SEQ_DATA_W = 32;

  typedef enum logic [2:0] {
    IDLE,
    WR_AW_W,
    WR_B,
    RD_AR,
    RD_R,
    RSP
  } seq_state_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef struct packed {
    logic                  write;
    logic [SEQ_ADDR_W-1:0] addr;
    logic [SEQ_DATA_W-1:0] wdata;
  } seq_cmd_t;

  // This master never issues exclusive accesses, so EXOKAY is unexpected and flagged too.
  function automatic logic resp_is_error(input logic [1:0] resp);
    return (resp == RESP_EXOKAY) || (resp == RESP_SLVERR) || (resp == RESP_DECERR);
  endfunction

endpackage

// File: rtl/aoc_axil_seq_stats.sv
// Transaction statistics: completed-transaction counter and sticky error flag.
module aoc_axil_seq_stats
  import aoc_axil_seq_pkg::*;
#(
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cap_valid,
  input  logic [1:0]           cap_resp,
  input  logic                 err_clr,
  output logic [CNT_WIDTH-1:0] txn_count,
  output logic                 err_sticky
);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      txn_count  <= '0;
      err_sticky <= 1'b0;
    end else begin
      if (cap_valid) begin
        txn_count <= txn_count + CNT_WIDTH'(1);
      end
      // A new error outranks a clear arriving in the same cycle.
      if (cap_valid && resp_is_error(cap_resp)) begin
        err_sticky <= 1'b1;
      end else if (err_clr) begin
        err_sticky <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/aoc_axil_sequencer.sv
// Single-outstanding AXI4-Lite master driving the aoc slave from a command stream.
module aoc_axil_sequencer
  import aoc_axil_seq_pkg::*;
#(
  parameter int ADDR_WIDTH = SEQ_ADDR_W,
  parameter int DATA_WIDTH = SEQ_DATA_W,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                    ACLK,
  input  logic                    ARESETN,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_write,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [DATA_WIDTH-1:0]   cmd_wdata,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic                    rsp_write,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic [1:0]              rsp_resp,
  output logic                    err_sticky,
  input  logic                    err_clr,
  output logic [CNT_WIDTH-1:0]    txn_count,
  output logic                    busy,
  output logic [ADDR_WIDTH-1:0]   M_AXI_AWADDR,
  output logic [2:0]              M_AXI_AWPROT,
  output logic                    M_AXI_AWVALID,
  input  logic                    M_AXI_AWREADY,
  output logic [DATA_WIDTH-1:0]   M_AXI_WDATA,
  output logic [DATA_WIDTH/8-1:0] M_AXI_WSTRB,
  output logic                    M_AXI_WVALID,
  input  logic                    M_AXI_WREADY,
  input  logic [1:0]              M_AXI_BRESP,
  input  logic                    M_AXI_BVALID,
  output logic                    M_AXI_BREADY,
  output logic [ADDR_WIDTH-1:0]   M_AXI_ARADDR,
  output logic [2:0]              M_AXI_ARPROT,
  output logic                    M_AXI_ARVALID,
  input  logic                    M_AXI_ARREADY,
  input  logic [DATA_WIDTH-1:0]   M_AXI_RDATA,
  input  logic [1:0]              M_AXI_RRESP,
  input  logic                    M_AXI_RVALID,
  output logic                    M_AXI_RREADY
);

  // Registers are word-aligned; the two byte-offset bits never reach the bus.
  localparam logic [ADDR_WIDTH-1:0] ADDR_MASK = ~ADDR_WIDTH'(3);

  seq_state_e            state_q, state_d;
  seq_cmd_t              cmd_q, cmd_d;
  logic                  awvalid_d, wvalid_d, bready_d, arvalid_d, rready_d;
  logic                  rsp_valid_d, rsp_write_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_d;
  logic [1:0]            rsp_resp_d;
  logic                  cap;

  assign M_AXI_AWADDR = cmd_q.addr;
  assign M_AXI_ARADDR = cmd_q.addr;
  assign M_AXI_WDATA  = cmd_q.wdata;
  assign M_AXI_AWPROT = 3'b000;
  assign M_AXI_ARPROT = 3'b000;
  assign M_AXI_WSTRB  = '1;

  // NOTE: every signal written here gets a default first, so no latch can be inferred.
  always_comb begin
    state_d     = state_q;
    cmd_d       = cmd_q;
    awvalid_d   = M_AXI_AWVALID;
    wvalid_d    = M_AXI_WVALID;
    bready_d    = M_AXI_BREADY;
    arvalid_d   = M_AXI_ARVALID;
    rready_d    = M_AXI_RREADY;
    rsp_valid_d = rsp_valid;
    rsp_write_d = rsp_write;
    rsp_rdata_d = rsp_rdata;
    rsp_resp_d  = rsp_resp;
    cap         = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (cmd_valid && cmd_ready) begin
          cmd_d.write = cmd_write;
          cmd_d.addr  = cmd_addr & ADDR_MASK;
          cmd_d.wdata = cmd_wdata;
          if (cmd_write) begin
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            state_d   = WR_AW_W;
          end else begin
            arvalid_d = 1'b1;
            state_d   = RD_AR;
          end
        end
      end
      WR_AW_W: begin
        // The VALID flags double as "still pending" markers for each channel.
        if (M_AXI_AWREADY) awvalid_d = 1'b0;
        if (M_AXI_WREADY)  wvalid_d  = 1'b0;
        if (!awvalid_d && !wvalid_d) begin
          bready_d = 1'b1;
          state_d  = WR_B;
        end
      end
      WR_B: begin
        if (M_AXI_BVALID && M_AXI_BREADY) begin
          bready_d    = 1'b0;
          cap         = 1'b1;
          rsp_write_d = cmd_q.write;
          rsp_rdata_d = '0;
          rsp_resp_d  = M_AXI_BRESP;
          rsp_valid_d = 1'b1;
          state_d     = RSP;
        end
      end
      RD_AR: begin
        if (M_AXI_ARREADY) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = RD_R;
        end
      end
      RD_R: begin
        if (M_AXI_RVALID && M_AXI_RREADY) begin
          rready_d    = 1'b0;
          cap         = 1'b1;
          rsp_write_d = cmd_q.write;
          rsp_rdata_d = M_AXI_RDATA;
          rsp_resp_d  = M_AXI_RRESP;
          rsp_valid_d = 1'b1;
          state_d     = RSP;
        end
      end
      RSP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state_q       <= IDLE;
      cmd_q         <= '0;
      cmd_ready     <= 1'b0;
      busy          <= 1'b0;
      M_AXI_AWVALID <= 1'b0;
      M_AXI_WVALID  <= 1'b0;
      M_AXI_BREADY  <= 1'b0;
      M_AXI_ARVALID <= 1'b0;
      M_AXI_RREADY  <= 1'b0;
      rsp_valid     <= 1'b0;
      rsp_write     <= 1'b0;
      rsp_rdata     <= '0;
      rsp_resp      <= '0;
    end else begin
      state_q       <= state_d;
      cmd_q         <= cmd_d;
      cmd_ready     <= (state_d == IDLE);
      busy          <= (state_d != IDLE);
      M_AXI_AWVALID <= awvalid_d;
      M_AXI_WVALID  <= wvalid_d;
      M_AXI_BREADY  <= bready_d;
      M_AXI_ARVALID <= arvalid_d;
      M_AXI_RREADY  <= rready_d;
      rsp_valid     <= rsp_valid_d;
      rsp_write     <= rsp_write_d;
      rsp_rdata     <= rsp_rdata_d;
      rsp_resp      <= rsp_resp_d;
    end
  end

  aoc_axil_seq_stats #(
    .CNT_WIDTH(CNT_WIDTH)
  ) u_stats (
    .clk        (ACLK),
    .rst_n      (ARESETN),
    .cap_valid  (cap),
    .cap_resp   (rsp_resp_d),
    .err_clr    (err_clr),
    .txn_count  (txn_count),
    .err_sticky (err_sticky)
  );

endmodule

// File: tb/tb_aoc_axil_sequencer.sv
// Bench for aoc_axil_sequencer: behavioural AXI4-Lite slave, response scoreboard, vector table.
module tb_aoc_axil_sequencer;
  import aoc_axil_seq_pkg::*;

  logic        ACLK = 1'b0;
  logic        ARESETN;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [3:0]  cmd_addr;
  logic [31:0] cmd_wdata;
  logic        rsp_valid, rsp_ready, rsp_write;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic        err_sticky, err_clr, busy;
  logic [15:0] txn_count;
  logic [3:0]  M_AXI_AWADDR, M_AXI_ARADDR, M_AXI_WSTRB;
  logic [2:0]  M_AXI_AWPROT, M_AXI_ARPROT;
  logic        M_AXI_AWVALID, M_AXI_AWREADY, M_AXI_WVALID, M_AXI_WREADY;
  logic        M_AXI_BVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_ARREADY;
  logic        M_AXI_RVALID, M_AXI_RREADY;
  logic [31:0] M_AXI_WDATA, M_AXI_RDATA;
  logic [1:0]  M_AXI_BRESP, M_AXI_RRESP;

  always #5 ACLK = ~ACLK;

  aoc_axil_sequencer #(.ADDR_WIDTH(4), .DATA_WIDTH(32), .CNT_WIDTH(16)) dut (
    .ACLK(ACLK), .ARESETN(ARESETN),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
    .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
    .err_sticky(err_sticky), .err_clr(err_clr), .txn_count(txn_count), .busy(busy),
    .M_AXI_AWADDR(M_AXI_AWADDR), .M_AXI_AWPROT(M_AXI_AWPROT),
    .M_AXI_AWVALID(M_AXI_AWVALID), .M_AXI_AWREADY(M_AXI_AWREADY),
    .M_AXI_WDATA(M_AXI_WDATA), .M_AXI_WSTRB(M_AXI_WSTRB),
    .M_AXI_WVALID(M_AXI_WVALID), .M_AXI_WREADY(M_AXI_WREADY),
    .M_AXI_BRESP(M_AXI_BRESP), .M_AXI_BVALID(M_AXI_BVALID), .M_AXI_BREADY(M_AXI_BREADY),
    .M_AXI_ARADDR(M_AXI_ARADDR), .M_AXI_ARPROT(M_AXI_ARPROT),
    .M_AXI_ARVALID(M_AXI_ARVALID), .M_AXI_ARREADY(M_AXI_ARREADY),
    .M_AXI_RDATA(M_AXI_RDATA), .M_AXI_RRESP(M_AXI_RRESP),
    .M_AXI_RVALID(M_AXI_RVALID), .M_AXI_RREADY(M_AXI_RREADY)
  );

  // ---------------- bookkeeping ----------------
  int n_tests = 0;
  int n_fail  = 0;
  int exp_txn = 0;
  int rsp_count = 0;
  int proto_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        write;
    logic [31:0] rdata;
    logic [1:0]  resp;
  } exp_t;
  exp_t exp_q[$];

  typedef struct {
    logic        write;
    logic [3:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic [1:0]  exp_resp;
  } vec_t;
  vec_t vecs[8];

  logic [31:0] model_mem [4];

  // ---------------- behavioural slave ----------------
  logic [31:0] mem [4];
  int          aw_delay, w_delay, ar_delay;
  int          aw_wait, w_wait, ar_wait;
  int          aw_hs_cnt = 0, w_hs_cnt = 0, ar_hs_cnt = 0;
  logic        aw_got, w_got, err_en;
  logic [3:0]  err_addr, s_awaddr, last_awaddr, last_araddr, last_wstrb;
  logic [2:0]  last_awprot, last_arprot;
  logic [31:0] s_wdata;
  logic        aw_hs, w_hs, ar_hs, wr_go;
  logic [3:0]  wr_addr;
  logic [31:0] wr_data;

  assign M_AXI_AWREADY = M_AXI_AWVALID && !aw_got && !M_AXI_BVALID && (aw_wait >= aw_delay);
  assign M_AXI_WREADY  = M_AXI_WVALID && !w_got && !M_AXI_BVALID && (w_wait >= w_delay);
  assign M_AXI_ARREADY = M_AXI_ARVALID && !M_AXI_RVALID && (ar_wait >= ar_delay);
  assign aw_hs   = M_AXI_AWVALID && M_AXI_AWREADY;
  assign w_hs    = M_AXI_WVALID && M_AXI_WREADY;
  assign ar_hs   = M_AXI_ARVALID && M_AXI_ARREADY;
  assign wr_addr = aw_hs ? M_AXI_AWADDR : s_awaddr;
  assign wr_data = w_hs ? M_AXI_WDATA : s_wdata;
  assign wr_go   = (aw_got || aw_hs) && (w_got || w_hs);

  always @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      aw_wait <= 0; w_wait <= 0; ar_wait <= 0;
      aw_got <= 1'b0; w_got <= 1'b0;
      s_awaddr <= '0; s_wdata <= '0;
      M_AXI_BVALID <= 1'b0; M_AXI_BRESP <= 2'b00;
      M_AXI_RVALID <= 1'b0; M_AXI_RDATA <= '0; M_AXI_RRESP <= 2'b00;
      for (int i = 0; i < 4; i++) mem[i] <= '0;
    end else begin
      aw_wait <= (M_AXI_AWVALID && !aw_hs) ? aw_wait + 1 : 0;
      w_wait  <= (M_AXI_WVALID && !w_hs) ? w_wait + 1 : 0;
      ar_wait <= (M_AXI_ARVALID && !ar_hs) ? ar_wait + 1 : 0;
      if (aw_hs) begin
        s_awaddr    <= M_AXI_AWADDR;
        last_awaddr <= M_AXI_AWADDR;
        last_awprot <= M_AXI_AWPROT;
        aw_hs_cnt   <= aw_hs_cnt + 1;
      end
      if (w_hs) begin
        s_wdata    <= M_AXI_WDATA;
        last_wstrb <= M_AXI_WSTRB;
        w_hs_cnt   <= w_hs_cnt + 1;
      end
      if (wr_go) begin
        aw_got <= 1'b0;
        w_got  <= 1'b0;
        M_AXI_BVALID <= 1'b1;
        if (err_en && wr_addr == err_addr) begin
          M_AXI_BRESP <= 2'b10;
        end else begin
          M_AXI_BRESP <= 2'b00;
          mem[wr_addr[3:2]] <= wr_data;
        end
      end else begin
        if (aw_hs) aw_got <= 1'b1;
        if (w_hs)  w_got  <= 1'b1;
        if (M_AXI_BVALID && M_AXI_BREADY) M_AXI_BVALID <= 1'b0;
      end
      if (ar_hs) begin
        M_AXI_RVALID <= 1'b1;
        M_AXI_RDATA  <= mem[M_AXI_ARADDR[3:2]];
        M_AXI_RRESP  <= 2'b00;
        last_araddr  <= M_AXI_ARADDR;
        last_arprot  <= M_AXI_ARPROT;
        ar_hs_cnt    <= ar_hs_cnt + 1;
      end else if (M_AXI_RVALID && M_AXI_RREADY) begin
        M_AXI_RVALID <= 1'b0;
      end
    end
  end

  // VALID must stay high until its handshake.
  logic aw_pend, w_pend, ar_pend;
  always @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      aw_pend <= 1'b0; w_pend <= 1'b0; ar_pend <= 1'b0;
    end else begin
      if ((aw_pend && !M_AXI_AWVALID) || (w_pend && !M_AXI_WVALID) || (ar_pend && !M_AXI_ARVALID))
        proto_err <= proto_err + 1;
      aw_pend <= M_AXI_AWVALID && !M_AXI_AWREADY;
      w_pend  <= M_AXI_WVALID && !M_AXI_WREADY;
      ar_pend <= M_AXI_ARVALID && !M_AXI_ARREADY;
    end
  end

  // ---------------- scoreboard ----------------
  initial begin
    forever begin
      @(negedge ACLK);
      if (ARESETN && rsp_valid && rsp_ready) begin
        if (exp_q.size() == 0) begin
          check("rsp_unexpected", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("rsp_write", 32'(rsp_write), 32'(e.write));
          check("rsp_rdata", rsp_rdata, e.rdata);
          check("rsp_resp", 32'(rsp_resp), 32'(e.resp));
          rsp_count++;
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic send(input logic w, input logic [3:0] a, input logic [31:0] d,
                      input logic [31:0] er, input logic [1:0] eresp);
    int   n;
    exp_t e;
    @(posedge ACLK); #1;
    cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d;
    n = 0;
    while (!cmd_ready && n < 200) begin
      @(posedge ACLK); #1;
      n++;
    end
    check("cmd_accept", 32'(n < 200), 32'd1);
    if (n < 200) begin
      e.write = w; e.rdata = er; e.resp = eresp;
      exp_q.push_back(e);
      exp_txn++;
    end
    @(posedge ACLK); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while ((exp_q.size() != 0 || busy) && n < 300) begin
      @(negedge ACLK);
      n++;
    end
    check({tag, "_drain"}, 32'(n < 300), 32'd1);
  endtask

  task automatic wait_rsp_valid(input string tag);
    int n = 0;
    while (!rsp_valid && n < 100) begin
      @(negedge ACLK);
      n++;
    end
    check({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- test sequence ----------------
  initial begin
    int aw0, w0, ar0, r0, n;

    vecs[0] = '{1'b1, 4'h0, 32'h1, 32'h0, 2'b00};
    vecs[1] = '{1'b1, 4'h4, 32'h2, 32'h0, 2'b00};
    vecs[2] = '{1'b1, 4'h8, 32'h3, 32'h0, 2'b00};
    vecs[3] = '{1'b1, 4'hC, 32'h4, 32'h0, 2'b00};
    vecs[4] = '{1'b0, 4'h0, 32'h0, 32'h1, 2'b00};
    vecs[5] = '{1'b0, 4'h4, 32'h0, 32'h2, 2'b00};
    vecs[6] = '{1'b0, 4'h8, 32'h0, 32'h3, 2'b00};
    vecs[7] = '{1'b0, 4'hC, 32'h0, 32'h4, 2'b00};

    ARESETN = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    rsp_ready = 1'b1; err_clr = 1'b0;
    aw_delay = 0; w_delay = 0; ar_delay = 0; err_en = 1'b0; err_addr = '0;
    for (int i = 0; i < 4; i++) model_mem[i] = '0;

    // Reset state
    repeat (3) @(posedge ACLK);
    #1;
    check("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    check("rst_valids", 32'({M_AXI_AWVALID, M_AXI_WVALID, M_AXI_ARVALID}), 32'd0);
    check("rst_readys", 32'({M_AXI_BREADY, M_AXI_RREADY}), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_txn_count", 32'(txn_count), 32'd0);
    check("rst_err_sticky", 32'(err_sticky), 32'd0);
    check("rst_awaddr", 32'(M_AXI_AWADDR), 32'd0);
    ARESETN = 1'b1;
    @(posedge ACLK);
    @(negedge ACLK);
    check("idle_cmd_ready", 32'(cmd_ready), 32'd1);

    // Table: four writes then four reads
    for (int i = 0; i < 8; i++) begin
      send(vecs[i].write, vecs[i].addr, vecs[i].wdata, vecs[i].exp_rdata, vecs[i].exp_resp);
      if (vecs[i].write) model_mem[vecs[i].addr[3:2]] = vecs[i].wdata;
    end
    wait_done("table");
    check("table_txn_count", 32'(txn_count), 32'd8);
    check("table_err_sticky", 32'(err_sticky), 32'd0);

    // AW held back behind W, then W held back behind AW
    aw0 = aw_hs_cnt; w0 = w_hs_cnt; r0 = rsp_count;
    aw_delay = 3;
    send(1'b1, 4'h8, 32'hA8, 32'h0, 2'b00);
    model_mem[2] = 32'hA8;
    wait_done("aw_late");
    check("aw_late_aw_hs", 32'(aw_hs_cnt - aw0), 32'd1);
    check("aw_late_w_hs", 32'(w_hs_cnt - w0), 32'd1);
    check("aw_late_rsp", 32'(rsp_count - r0), 32'd1);
    aw0 = aw_hs_cnt; w0 = w_hs_cnt; r0 = rsp_count;
    aw_delay = 0; w_delay = 3;
    send(1'b1, 4'hC, 32'hAC, 32'h0, 2'b00);
    model_mem[3] = 32'hAC;
    wait_done("w_late");
    check("w_late_aw_hs", 32'(aw_hs_cnt - aw0), 32'd1);
    check("w_late_w_hs", 32'(w_hs_cnt - w0), 32'd1);
    check("w_late_rsp", 32'(rsp_count - r0), 32'd1);
    w_delay = 0;
    send(1'b0, 4'hC, 32'h0, model_mem[3], 2'b00);
    wait_done("w_late_rd");

    // Response back-pressure: rsp held stable, new command ignored
    rsp_ready = 1'b0;
    ar0 = ar_hs_cnt;
    send(1'b0, 4'h8, 32'h0, model_mem[2], 2'b00);
    wait_rsp_valid("stall");
    @(posedge ACLK); #1;
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 4'h0;
    for (int k = 0; k < 10; k++) begin
      @(negedge ACLK);
      check("stall_rsp_valid", 32'(rsp_valid), 32'd1);
      check("stall_rsp_rdata", rsp_rdata, model_mem[2]);
      check("stall_cmd_ready", 32'(cmd_ready), 32'd0);
    end
    check("stall_ar_count", 32'(ar_hs_cnt - ar0), 32'd1);
    @(posedge ACLK); #1;
    cmd_valid = 1'b0; rsp_ready = 1'b1;
    wait_done("stall");

    // Slave error, sticky flag and clear
    err_en = 1'b1; err_addr = 4'h4;
    send(1'b1, 4'h4, 32'hDEAD_BEEF, 32'h0, 2'b10);
    wait_done("slverr");
    check("slverr_sticky", 32'(err_sticky), 32'd1);
    check("slverr_txn_count", 32'(txn_count), 32'(exp_txn));
    @(posedge ACLK); #1; err_clr = 1'b1;
    @(posedge ACLK); #1; err_clr = 1'b0;
    @(negedge ACLK);
    check("errclr_sticky", 32'(err_sticky), 32'd0);
    check("errclr_txn_count", 32'(txn_count), 32'(exp_txn));

    // Error capture coinciding with err_clr: set wins, then the held clear takes effect
    @(posedge ACLK); #1; err_clr = 1'b1;
    send(1'b1, 4'h4, 32'h1234, 32'h0, 2'b10);
    wait_rsp_valid("setwins");
    check("setwins_sticky", 32'(err_sticky), 32'd1);
    @(posedge ACLK); #1; err_clr = 1'b0;
    wait_done("setwins");
    check("setwins_cleared", 32'(err_sticky), 32'd0);
    err_en = 1'b0;
    send(1'b0, 4'h4, 32'h0, model_mem[1], 2'b00);
    wait_done("slverr_rd");

    // Unaligned address is word-aligned on the bus
    send(1'b1, 4'h7, 32'h77, 32'h0, 2'b00);
    model_mem[1] = 32'h77;
    wait_done("align_wr");
    check("align_awaddr", 32'(last_awaddr), 32'h4);
    check("align_wstrb", 32'(last_wstrb), 32'hF);
    check("align_awprot", 32'(last_awprot), 32'h0);
    send(1'b0, 4'h5, 32'h0, model_mem[1], 2'b00);
    wait_done("align_rd");
    check("align_araddr", 32'(last_araddr), 32'h4);
    check("align_arprot", 32'(last_arprot), 32'h0);
    check("proto_valid_stable", 32'(proto_err), 32'd0);

    // Reset while ARVALID is high
    ar_delay = 6;
    send(1'b0, 4'h0, 32'h0, model_mem[0], 2'b00);
    n = 0;
    while (!M_AXI_ARVALID && n < 50) begin
      @(negedge ACLK);
      n++;
    end
    check("midrst_arvalid_high", 32'(M_AXI_ARVALID), 32'd1);
    @(negedge ACLK); #2;
    ARESETN = 1'b0;
    #1;
    check("midrst_arvalid", 32'(M_AXI_ARVALID), 32'd0);
    check("midrst_readys", 32'({M_AXI_BREADY, M_AXI_RREADY}), 32'd0);
    check("midrst_cmd_ready", 32'(cmd_ready), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("midrst_rsp_rdata", rsp_rdata, 32'h0);
    check("midrst_txn_count", 32'(txn_count), 32'd0);
    check("midrst_err_sticky", 32'(err_sticky), 32'd0);
    check("midrst_addr", 32'({M_AXI_AWADDR, M_AXI_ARADDR}), 32'd0);
    check("midrst_wdata", M_AXI_WDATA, 32'h0);
    exp_q.delete();
    exp_txn = 0;
    for (int i = 0; i < 4; i++) model_mem[i] = '0;
    ar_delay = 0;
    repeat (2) @(posedge ACLK);
    #1 ARESETN = 1'b1;
    send(1'b0, 4'h0, 32'h0, model_mem[0], 2'b00);
    wait_done("postrst");
    check("postrst_txn_count", 32'(txn_count), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
